// File: rtl/fft_pkg.sv
// Shared types and helpers for the FFT output reorder buffer.
package fft_pkg;

    typedef enum logic [1:0] {
        EMPTY    = 2'd0,
        FILLING  = 2'd1,
        FULL     = 2'd2,
        DRAINING = 2'd3
    } bank_state_t;

    typedef enum logic {
        R_IDLE  = 1'b0,
        R_DRAIN = 1'b1
    } rd_state_t;

    function automatic int nfft(input int size_buffer);
        return 1 << size_buffer;
    endfunction

endpackage

// File: rtl/fft_half_ram.sv
// Simple dual-port RAM: one write port, one registered read port.
module fft_half_ram #(
    parameter int ADDR_W = 3,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        if (re) rdata <= mem[raddr];
    end

endmodule

// File: rtl/fft_output_reorder_buffer.sv
// Ping-pong buffer turning (k, k+NFFT/2) butterfly pairs into a natural-order stream.
// Read FSM: R_IDLE | waiting for bank[rd_bank] FULL ; R_DRAIN | streaming bins 0..NFFT-1
module fft_output_reorder_buffer
    import fft_pkg::*;
#(
    parameter int SIZE_BUFFER   = 3,
    parameter int SIZE_OUT_DATA = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [SIZE_OUT_DATA-1:0] in_lo_i,
    input  logic [SIZE_OUT_DATA-1:0] in_lo_q,
    input  logic [SIZE_OUT_DATA-1:0] in_hi_i,
    input  logic [SIZE_OUT_DATA-1:0] in_hi_q,
    input  logic                     in_valid,
    output logic                     mutDone,
    output logic                     busy,
    output logic                     overflow,
    output logic [SIZE_OUT_DATA-1:0] out_i,
    output logic [SIZE_OUT_DATA-1:0] out_q,
    output logic [SIZE_BUFFER-1:0]   out_index,
    output logic                     out_last,
    output logic                     out_valid,
    input  logic                     out_ready
);

    localparam int NFFT = nfft(SIZE_BUFFER);
    localparam int AW   = SIZE_BUFFER - 1;
    localparam int DW   = 2 * SIZE_OUT_DATA;
    localparam logic [AW-1:0]          WR_LAST = AW'(NFFT / 2 - 1);
    localparam logic [SIZE_BUFFER-1:0] RD_LAST = SIZE_BUFFER'(NFFT - 1);

    bank_state_t bank_st [2];
    logic        wr_bank;
    logic [AW-1:0] wr_cnt;
    logic        accept, wr_last;

    rd_state_t   rd_state, rd_state_nxt;
    logic        rd_bank, all_issued;
    logic [SIZE_BUFFER-1:0] rd_cnt;
    logic        start, issue, release_bank;

    logic        ram_vld;
    logic [SIZE_BUFFER-1:0] ram_idx;
    logic [DW-1:0] lo_rdata, hi_rdata, ram_sel_data;
    logic        skid_vld, skid_vld_nxt;
    logic [DW-1:0] skid_data;
    logic [SIZE_BUFFER-1:0] skid_idx;
    logic        out_free;

    assign accept  = in_valid && (bank_st[wr_bank] == EMPTY || bank_st[wr_bank] == FILLING);
    assign wr_last = accept && (wr_cnt == WR_LAST);
    assign busy    = (bank_st[wr_bank] == FULL) || (bank_st[wr_bank] == DRAINING);

    fft_half_ram #(.ADDR_W(SIZE_BUFFER), .DATA_W(DW)) u_lo_ram (
        .clk   (clk),
        .we    (accept),
        .waddr ({wr_bank, wr_cnt}),
        .wdata ({in_lo_i, in_lo_q}),
        .re    (issue),
        .raddr ({rd_bank, rd_cnt[AW-1:0]}),
        .rdata (lo_rdata)
    );

    fft_half_ram #(.ADDR_W(SIZE_BUFFER), .DATA_W(DW)) u_hi_ram (
        .clk   (clk),
        .we    (accept),
        .waddr ({wr_bank, wr_cnt}),
        .wdata ({in_hi_i, in_hi_q}),
        .re    (issue),
        .raddr ({rd_bank, rd_cnt[AW-1:0]}),
        .rdata (hi_rdata)
    );

    assign ram_sel_data = ram_idx[SIZE_BUFFER-1] ? hi_rdata : lo_rdata;

    always_comb begin
        rd_state_nxt = rd_state;
        start        = 1'b0;
        release_bank = 1'b0;
        case (rd_state)
            R_IDLE: begin
                if (bank_st[rd_bank] == FULL) begin
                    start        = 1'b1;
                    rd_state_nxt = R_DRAIN;
                end
            end
            R_DRAIN: begin
                if (out_valid && out_ready && out_last) begin
                    release_bank = 1'b1;
                    rd_state_nxt = R_IDLE;
                end
            end
            default: rd_state_nxt = R_IDLE;
        endcase
    end

    // A read is only issued if its data is guaranteed a slot (output or skid) next cycle.
    always_comb begin
        out_free     = !out_valid || out_ready;
        skid_vld_nxt = out_free ? (skid_vld && ram_vld) : (skid_vld || ram_vld);
        issue        = (start || (rd_state == R_DRAIN && !all_issued)) && !skid_vld_nxt;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_bank  <= 1'b0;
            wr_cnt   <= '0;
            mutDone  <= 1'b0;
            overflow <= 1'b0;
            for (int b = 0; b < 2; b++) bank_st[b] <= EMPTY;
        end else begin
            mutDone  <= wr_last;
            overflow <= overflow || (in_valid && !accept);
            if (accept) wr_cnt <= wr_cnt + AW'(1);
            if (wr_last) wr_bank <= ~wr_bank;
            for (int b = 0; b < 2; b++) begin
                if (accept && wr_bank == 1'(b)) bank_st[b] <= wr_last ? FULL : FILLING;
                if (start && rd_bank == 1'(b)) bank_st[b] <= DRAINING;
                if (release_bank && rd_bank == 1'(b)) bank_st[b] <= EMPTY;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_state   <= R_IDLE;
            rd_bank    <= 1'b0;
            rd_cnt     <= '0;
            all_issued <= 1'b0;
            ram_vld    <= 1'b0;
            ram_idx    <= '0;
            skid_vld   <= 1'b0;
            skid_data  <= '0;
            skid_idx   <= '0;
            out_valid  <= 1'b0;
            out_last   <= 1'b0;
            out_i      <= '0;
            out_q      <= '0;
            out_index  <= '0;
        end else begin
            rd_state <= rd_state_nxt;
            if (issue) begin
                rd_cnt <= rd_cnt + SIZE_BUFFER'(1);
                if (rd_cnt == RD_LAST) all_issued <= 1'b1;
            end
            if (release_bank) begin
                rd_bank    <= ~rd_bank;
                rd_cnt     <= '0;
                all_issued <= 1'b0;
            end
            ram_vld <= issue;
            if (issue) ram_idx <= rd_cnt;
            skid_vld <= skid_vld_nxt;
            if (ram_vld && (out_free == skid_vld)) begin
                skid_data <= ram_sel_data;
                skid_idx  <= ram_idx;
            end
            if (out_free) begin
                out_valid <= skid_vld || ram_vld;
                out_last  <= 1'b0;
                if (skid_vld) begin
                    {out_i, out_q} <= skid_data;
                    out_index      <= skid_idx;
                    out_last       <= (skid_idx == RD_LAST);
                end else if (ram_vld) begin
                    {out_i, out_q} <= ram_sel_data;
                    out_index      <= ram_idx;
                    out_last       <= (ram_idx == RD_LAST);
                end
            end
        end
    end

endmodule

// File: tb/tb_fft_output_reorder_buffer.sv
// Self-checking bench for fft_output_reorder_buffer (SIZE_BUFFER=3, NFFT=8).
module tb_fft_output_reorder_buffer;

    localparam int SB   = 3;
    localparam int DW   = 16;
    localparam int NFFT = 8;
    localparam int HALF = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [DW-1:0] in_lo_i = '0, in_lo_q = '0, in_hi_i = '0, in_hi_q = '0;
    logic          in_valid = 1'b0;
    logic          mutDone, busy, overflow;
    logic [DW-1:0] out_i, out_q;
    logic [SB-1:0] out_index;
    logic          out_last, out_valid;
    logic          out_ready;
    logic          ready_man = 1'b1;
    logic          rand_en = 1'b0;
    logic          rand_bit = 1'b1;

    assign out_ready = rand_en ? rand_bit : ready_man;

    typedef struct packed {
        logic [DW-1:0] i;
        logic [DW-1:0] q;
        logic [SB-1:0] idx;
        logic          last;
    } sample_t;

    sample_t got_q[$];
    sample_t exp_q[$];
    sample_t table_v [NFFT];
    int checks = 0;
    int errors = 0;
    int mutdone_cnt = 0;

    fft_output_reorder_buffer #(.SIZE_BUFFER(SB), .SIZE_OUT_DATA(DW)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_lo_i   (in_lo_i),
        .in_lo_q   (in_lo_q),
        .in_hi_i   (in_hi_i),
        .in_hi_q   (in_hi_q),
        .in_valid  (in_valid),
        .mutDone   (mutDone),
        .busy      (busy),
        .overflow  (overflow),
        .out_i     (out_i),
        .out_q     (out_q),
        .out_index (out_index),
        .out_last  (out_last),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    // Handshakes are observed mid-cycle, so each recorded sample is the one taken at the next rising edge.
    always @(negedge clk) begin
        if (reset && out_valid && out_ready) got_q.push_back('{i: out_i, q: out_q, idx: out_index, last: out_last});
        if (reset && mutDone) mutdone_cnt++;
    end

    always @(posedge clk) begin
        #1;
        rand_bit = ($urandom_range(0, 9) < 7);
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    task automatic add_exp(input logic [DW-1:0] i, input logic [DW-1:0] q, input int idx);
        exp_q.push_back('{i: i, q: q, idx: SB'(idx), last: (idx == NFFT - 1)});
    endtask

    task automatic send_pair(input logic [DW-1:0] li, input logic [DW-1:0] lq,
                             input logic [DW-1:0] hi, input logic [DW-1:0] hq, input bit wait_busy);
        int c = 0;
        if (wait_busy) begin
            while (busy && c < 200) begin
                step();
                c++;
            end
            if (busy) begin
                checks++;
                errors++;
                $display("FAIL busy_wait: busy=1 after 200 cycles, expected 0");
            end
        end
        in_lo_i = li; in_lo_q = lq; in_hi_i = hi; in_hi_q = hq;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
    endtask

    task automatic send_table_frame(input bit gapped);
        for (int k = 0; k < HALF; k++) begin
            if (gapped) step();
            send_pair(table_v[k].i, table_v[k].q, table_v[k + HALF].i, table_v[k + HALF].q, 1'b0);
        end
    endtask

    task automatic exp_table();
        for (int k = 0; k < NFFT; k++) exp_q.push_back(table_v[k]);
    endtask

    task automatic wait_outputs(input int n, input int budget);
        int c = 0;
        while (got_q.size() < n && c < budget) begin
            step();
            c++;
        end
        if (got_q.size() < n) begin
            checks++;
            errors++;
            $display("FAIL output_timeout: got %0d samples, expected %0d", got_q.size(), n);
        end
    endtask

    task automatic compare_stream(input string name);
        sample_t e, g;
        int n = 0;
        chk($sformatf("%s count", name), 64'(got_q.size()), 64'(exp_q.size()));
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front();
            g = got_q.pop_front();
            chk($sformatf("%s sample[%0d] {i,q,idx,last}", name, n), 64'(g), 64'(e));
            n++;
        end
        exp_q.delete();
        got_q.delete();
    endtask

    initial begin
        logic [DW-1:0] lo_i [HALF];
        logic [DW-1:0] lo_q [HALF];
        logic [DW-1:0] hi_i [HALF];
        logic [DW-1:0] hi_q [HALF];
        int c;

        // Natural-order expectation of the test-plan frame: pairs (k, 100+k), I=Q.
        table_v[0] = '{16'd0,   16'd0,   3'd0, 1'b0};
        table_v[1] = '{16'd1,   16'd1,   3'd1, 1'b0};
        table_v[2] = '{16'd2,   16'd2,   3'd2, 1'b0};
        table_v[3] = '{16'd3,   16'd3,   3'd3, 1'b0};
        table_v[4] = '{16'd100, 16'd100, 3'd4, 1'b0};
        table_v[5] = '{16'd101, 16'd101, 3'd5, 1'b0};
        table_v[6] = '{16'd102, 16'd102, 3'd6, 1'b0};
        table_v[7] = '{16'd103, 16'd103, 3'd7, 1'b1};

        // Reset values
        repeat (3) step();
        chk("reset out_valid", 64'(out_valid), 0);
        chk("reset out_last", 64'(out_last), 0);
        chk("reset mutDone", 64'(mutDone), 0);
        chk("reset busy", 64'(busy), 0);
        chk("reset overflow", 64'(overflow), 0);
        chk("reset out_i", 64'(out_i), 0);
        chk("reset out_q", 64'(out_q), 0);
        chk("reset out_index", 64'(out_index), 0);
        reset = 1'b1;
        step();

        // Single frame with latency checks
        mutdone_cnt = 0;
        exp_table();
        send_table_frame(1'b0);
        chk("single mutDone at T", 64'(mutDone), 1);
        chk("single out_valid at T", 64'(out_valid), 0);
        step();
        chk("single mutDone at T+1", 64'(mutDone), 0);
        chk("single out_valid at T+1", 64'(out_valid), 0);
        step();
        chk("single out_valid at T+2", 64'(out_valid), 1);
        chk("single out_index at T+2", 64'(out_index), 0);
        wait_outputs(NFFT, 100);
        repeat (5) step();
        compare_stream("single");
        chk("single mutDone pulses", 64'(mutdone_cnt), 1);

        // Gapped input
        mutdone_cnt = 0;
        exp_table();
        send_table_frame(1'b1);
        wait_outputs(NFFT, 100);
        repeat (5) step();
        compare_stream("gapped");
        chk("gapped mutDone pulses", 64'(mutdone_cnt), 1);

        // Backpressure at index 3
        exp_table();
        send_table_frame(1'b0);
        c = 0;
        while (!(out_valid && out_index == 3) && c < 50) begin
            step();
            c++;
        end
        chk("bp reached index 3", 64'(out_valid && out_index == 3), 1);
        ready_man = 1'b0;
        for (int s = 0; s < 5; s++) begin
            step();
            chk($sformatf("bp hold%0d out_valid", s), 64'(out_valid), 1);
            chk($sformatf("bp hold%0d out_index", s), 64'(out_index), 3);
            chk($sformatf("bp hold%0d out_i", s), 64'(out_i), 3);
        end
        ready_man = 1'b1;
        wait_outputs(NFFT, 100);
        repeat (5) step();
        compare_stream("backpressure");

        // Back-to-back frames; the source only holds off while busy is high
        mutdone_cnt = 0;
        for (int f = 0; f < 3; f++) begin
            for (int k = 0; k < HALF; k++) add_exp(DW'(f * 16 + k), DW'(f * 16 + k + 50), k);
            for (int k = 0; k < HALF; k++) add_exp(DW'(f * 16 + 100 + k), DW'(f * 16 + 150 + k), k + HALF);
        end
        for (int f = 0; f < 3; f++)
            for (int k = 0; k < HALF; k++)
                send_pair(DW'(f * 16 + k), DW'(f * 16 + k + 50), DW'(f * 16 + 100 + k), DW'(f * 16 + 150 + k), 1'b1);
        wait_outputs(3 * NFFT, 300);
        repeat (5) step();
        compare_stream("b2b");
        chk("b2b mutDone pulses", 64'(mutdone_cnt), 3);
        chk("b2b overflow", 64'(overflow), 0);

        // Randomized data, input gaps and output backpressure against the reference queue
        mutdone_cnt = 0;
        rand_en = 1'b1;
        for (int f = 0; f < 4; f++) begin
            for (int k = 0; k < HALF; k++) begin
                lo_i[k] = DW'($urandom); lo_q[k] = DW'($urandom);
                hi_i[k] = DW'($urandom); hi_q[k] = DW'($urandom);
            end
            for (int k = 0; k < HALF; k++) add_exp(lo_i[k], lo_q[k], k);
            for (int k = 0; k < HALF; k++) add_exp(hi_i[k], hi_q[k], k + HALF);
            for (int k = 0; k < HALF; k++) begin
                repeat ($urandom_range(0, 2)) step();
                send_pair(lo_i[k], lo_q[k], hi_i[k], hi_q[k], 1'b1);
            end
        end
        wait_outputs(4 * NFFT, 2000);
        rand_en = 1'b0;
        repeat (5) step();
        compare_stream("random");
        chk("random mutDone pulses", 64'(mutdone_cnt), 4);
        chk("random overflow", 64'(overflow), 0);

        // Overflow: output stalled, third frame dropped entirely
        mutdone_cnt = 0;
        ready_man = 1'b0;
        for (int f = 0; f < 2; f++) begin
            for (int k = 0; k < HALF; k++) add_exp(DW'(200 + f * 16 + k), DW'(300 + k), k);
            for (int k = 0; k < HALF; k++) add_exp(DW'(400 + f * 16 + k), DW'(500 + k), k + HALF);
        end
        for (int f = 0; f < 3; f++) begin
            for (int k = 0; k < HALF; k++)
                send_pair(DW'(200 + f * 16 + k), DW'(300 + k), DW'(400 + f * 16 + k), DW'(500 + k), 1'b0);
            if (f == 1) begin
                chk("ovf busy after frame 2", 64'(busy), 1);
                chk("ovf overflow before frame 3", 64'(overflow), 0);
            end
        end
        chk("ovf overflow after frame 3", 64'(overflow), 1);
        chk("ovf mutDone pulses", 64'(mutdone_cnt), 2);
        ready_man = 1'b1;
        wait_outputs(2 * NFFT, 200);
        repeat (20) step();
        compare_stream("overflow");
        chk("ovf overflow sticky", 64'(overflow), 1);

        // Reset mid-drain at index 5
        exp_q.delete();
        send_table_frame(1'b0);
        c = 0;
        while (!(out_valid && out_index == 5) && c < 50) begin
            step();
            c++;
        end
        chk("rst reached index 5", 64'(out_valid && out_index == 5), 1);
        reset = 1'b0;
        #1;
        chk("rst async out_valid", 64'(out_valid), 0);
        chk("rst async out_i", 64'(out_i), 0);
        chk("rst async out_q", 64'(out_q), 0);
        chk("rst async out_index", 64'(out_index), 0);
        chk("rst async out_last", 64'(out_last), 0);
        chk("rst async overflow", 64'(overflow), 0);
        step();
        step();
        reset = 1'b1;
        got_q.delete();
        mutdone_cnt = 0;
        repeat (10) step();
        chk("rst no stale output", 64'(got_q.size()), 0);
        exp_table();
        send_table_frame(1'b0);
        wait_outputs(NFFT, 100);
        repeat (5) step();
        compare_stream("post_reset");
        chk("post_reset mutDone pulses", 64'(mutdone_cnt), 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
